// File: rtl/snake_body_if.sv
// Segment read port of the snake body buffer: the renderer drives rd_idx and
// receives the registered coordinates of that segment one frame later.
interface snake_body_if #(
   parameter int unsigned MAX_LEN = 32
);
   localparam int unsigned IDX_W = $clog2(MAX_LEN);

   logic [IDX_W-1:0] rd_idx;
   logic [9:0]       rd_x;
   logic [9:0]       rd_y;
   logic             rd_valid;

   modport master (output rd_idx, input rd_x, rd_y, rd_valid);
   modport slave  (input rd_idx, output rd_x, rd_y, rd_valid);
endinterface

// File: rtl/snake_body.sv
// Snake body history, growth, scoring and collision FSM. The buffer records the
// head once per body step; segments are read newest-first through the rd port.
module snake_body #(
   parameter int unsigned MAX_LEN  = 32,
   parameter int unsigned INIT_LEN = 4,
   parameter int unsigned STEP_DIV = 4,
   parameter int unsigned SEG_SIZE = 12
) (
   input  logic                       frame_clk,
   input  logic                       Reset,
   input  logic                       start,
   input  logic [9:0]                 head_x,
   input  logic [9:0]                 head_y,
   input  logic [9:0]                 food_x,
   input  logic [9:0]                 food_y,
   snake_body_if.slave                rd,
   output logic [$clog2(MAX_LEN):0]   length,
   output logic [7:0]                 score,
   output logic                       food_eaten,
   output logic                       dead,
   output logic [1:0]                 state
);

   localparam int unsigned IDX_W = $clog2(MAX_LEN);
   localparam int unsigned LEN_W = IDX_W + 1;
   localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [9:0]       SEG       = 10'(SEG_SIZE);
   localparam logic [9:0]       X_MAX     = 10'(639 - SEG_SIZE);
   localparam logic [9:0]       Y_MAX     = 10'(479 - SEG_SIZE);
   localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_INIT  = LEN_W'(INIT_LEN);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] length_q, length_d;
   logic [LEN_W-1:0] filled_q, filled_d;
   logic [7:0]       score_q, score_d;
   logic             food_eaten_q, food_eaten_d;
   logic             grow_pending_q, grow_pending_d;
   logic             hit_prev_q, hit_prev_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [9:0]       rd_x_q, rd_x_d;
   logic [9:0]       rd_y_q, rd_y_d;
   logic             rd_valid_q, rd_valid_d;

   logic [9:0] buf_x_q [MAX_LEN];
   logic [9:0] buf_y_q [MAX_LEN];

   logic       init_all, wr_en;
   logic       step, collide, eat;
   logic [9:0] dx, dy;
   logic       food_hit, wall_hit, self_hit;

   always_comb begin
      dx       = (head_x >= food_x) ? head_x - food_x : food_x - head_x;
      dy       = (head_y >= food_y) ? head_y - food_y : food_y - head_y;
      food_hit = (dx < SEG) && (dy < SEG);
      wall_hit = (head_x < SEG) || (head_x > X_MAX) || (head_y < SEG) || (head_y > Y_MAX);
      // Offset k counts back from the newest entry; the tail (k = length-1) is
      // excluded because it vacates on this same step.
      self_hit = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if ((LEN_W'(k + 2) <= length_q) && (LEN_W'(k) < filled_q) &&
             (buf_x_q[wr_ptr_q - IDX_W'(k + 1)] == head_x) &&
             (buf_y_q[wr_ptr_q - IDX_W'(k + 1)] == head_y))
            self_hit = 1'b1;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      length_d       = length_q;
      filled_d       = filled_q;
      score_d        = score_q;
      food_eaten_d   = 1'b0;
      grow_pending_d = grow_pending_q;
      hit_prev_d     = hit_prev_q;
      step_cnt_d     = step_cnt_q;
      wr_ptr_d       = wr_ptr_q;
      init_all       = 1'b0;
      wr_en          = 1'b0;
      step           = 1'b0;
      collide        = 1'b0;
      eat            = 1'b0;

      case (state_q)
         IDLE, DEAD: begin
            if (start) begin
               state_d        = RUN;
               init_all       = 1'b1;
               length_d       = LEN_INIT;
               filled_d       = '0;
               score_d        = '0;
               grow_pending_d = 1'b0;
               hit_prev_d     = 1'b0;
               step_cnt_d     = '0;
               wr_ptr_d       = '0;
            end
         end
         RUN: begin
            step       = (step_cnt_q == STEP_LAST);
            step_cnt_d = step ? '0 : step_cnt_q + CNT_W'(1);
            collide    = step && (wall_hit || self_hit);
            eat        = food_hit && !hit_prev_q && !collide;
            hit_prev_d = food_hit;

            if (collide) begin
               state_d = DEAD;
            end else if (step) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + IDX_W'(1);
               if (filled_q != LEN_FULL) filled_d = filled_q + LEN_W'(1);
               if (grow_pending_q) begin
                  grow_pending_d = 1'b0;
                  if (length_q != LEN_FULL) length_d = length_q + LEN_W'(1);
               end
            end

            // A new eat re-arms growth even if this step just consumed it.
            if (eat) begin
               food_eaten_d   = 1'b1;
               grow_pending_d = 1'b1;
               if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_valid_d = ({1'b0, rd.rd_idx} < length_q);
      rd_x_d     = '0;
      rd_y_d     = '0;
      if (rd_valid_d) begin
         rd_x_d = buf_x_q[wr_ptr_q - IDX_W'(1) - rd.rd_idx];
         rd_y_d = buf_y_q[wr_ptr_q - IDX_W'(1) - rd.rd_idx];
      end
   end

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_q        <= IDLE;
         length_q       <= '0;
         filled_q       <= '0;
         score_q        <= '0;
         food_eaten_q   <= 1'b0;
         grow_pending_q <= 1'b0;
         hit_prev_q     <= 1'b0;
         step_cnt_q     <= '0;
         wr_ptr_q       <= '0;
         rd_x_q         <= '0;
         rd_y_q         <= '0;
         rd_valid_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q        <= state_d;
         length_q       <= length_d;
         filled_q       <= filled_d;
         score_q        <= score_d;
         food_eaten_q   <= food_eaten_d;
         grow_pending_q <= grow_pending_d;
         hit_prev_q     <= hit_prev_d;
         step_cnt_q     <= step_cnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_x_q         <= rd_x_d;
         rd_y_q         <= rd_y_d;
         rd_valid_q     <= rd_valid_d;
      end
   end

   // NOTE: the buffer has no reset; entries are unobservable until RUN entry
   // overwrites all of them, so a reset would only cost routing.
   always_ff @(posedge frame_clk) begin
      if (init_all) begin
         for (int k = 0; k < MAX_LEN; k++) begin
            buf_x_q[k] <= head_x;
            buf_y_q[k] <= head_y;
         end
      end else if (wr_en) begin
         buf_x_q[wr_ptr_q] <= head_x;
         buf_y_q[wr_ptr_q] <= head_y;
      end
   end

   assign rd.rd_x     = rd_x_q;
   assign rd.rd_y     = rd_y_q;
   assign rd.rd_valid = rd_valid_q;
   assign length      = length_q;
   assign score       = score_q;
   assign food_eaten  = food_eaten_q;
   assign dead        = (state_q == DEAD);
   assign state       = state_q;

endmodule
